// File: rtl/rs232_tx_buffered.sv
// RS232 8N1 transmitter with a small byte FIFO in front of the shifter.
// Baud rate is selected per frame by fsel (115200 / 9600 bps from a 25 MHz clock).
module rs232_tx_buffered #(
   parameter logic [11:0] LIMIT_FAST = 12'd217,
   parameter logic [11:0] LIMIT_SLOW = 12'd2604,
   parameter int          AW         = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fsel,
   input  logic       start,
   input  logic [7:0] data,
   output logic       rdy,
   output logic       busy,
   output logic       TxD,
   output logic       dbg_state
);

   // Handshake: a byte is taken on every cycle where start && rdy; start with rdy low is dropped.
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

   state_t        state, state_nxt;
   logic [7:0]    mem [2**AW];
   logic [AW-1:0] rd, wr;
   logic [AW:0]   count, count_nxt;
   logic [9:0]    shreg;
   logic [11:0]   lim, tick;
   logic [3:0]    bitcnt;
   logic          busy_q;
   logic          push, pop, bit_end, tx_nxt;

   assign push    = start & rdy;
   assign pop     = (state == IDLE) & (count != '0);
   assign bit_end = (state == SEND) & (tick == lim);

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr] <= data;
   end

   // rdy is a flop so it reflects the count held in the FIFO this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
         rdy   <= 1'b1;
      end else begin
         if (push) wr <= wr + 1'b1;
         if (pop)  rd <= rd + 1'b1;
         count <= count_nxt;
         rdy   <= (count_nxt != FULL);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = SEND;
         SEND:    if (bit_end && (bitcnt == 4'd9)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_nxt = 1'b1;
      if (state == SEND) tx_nxt = shreg[0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg  <= '1;
         lim    <= '0;
         tick   <= '0;
         bitcnt <= '0;
      end else if (pop) begin
         shreg  <= {1'b1, mem[rd], 1'b0};
         lim    <= fsel ? LIMIT_FAST : LIMIT_SLOW;
         tick   <= '0;
         bitcnt <= '0;
      end else if (state == SEND) begin
         if (bit_end) begin
            tick   <= '0;
            shreg  <= {1'b1, shreg[9:1]};
            bitcnt <= bitcnt + 1'b1;
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

   // TxD is registered, so the line trails the FSM by one clock; busy_q covers that trailing cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         TxD    <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         TxD    <= tx_nxt;
         busy_q <= (state == SEND);
      end
   end

   assign busy      = busy_q | (state == SEND) | (count != '0);
   assign dbg_state = state;

endmodule
